// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencing controller: merges halt, freeze, load-use and branch-wait
// requests into one PC stall / bubble command and keeps saturating perf counters.
module fetch_seq_ctrl #(
  parameter int LOAD_BUBBLES = 1,
  parameter int BR_TIMEOUT   = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 halt_req,
  input  logic                 resume,
  input  logic                 ext_stall,
  input  logic                 load_hazard,
  input  logic                 branch_detect,
  input  logic                 branch_resolved,
  input  logic                 branch_taken,
  input  logic                 clear_counts,
  output logic                 pc_stall,
  output logic                 bubble,
  output logic                 flush,
  output logic                 halted,
  output logic                 br_timeout_err,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] bubble_count
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LOAD_BUB = 2'b01,
    BR_WAIT  = 2'b10,
    HALT     = 2'b11
  } state_e;

  // The first load bubble is issued from RUN, so LOAD_BUB only covers the rest.
  localparam logic [7:0] LB_INIT = 8'((LOAD_BUBBLES > 1) ? (LOAD_BUBBLES - 2) : 0);
  localparam logic [7:0] BR_LAST = 8'(BR_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;
  logic                 stall_c, bubble_c, flush_c;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    if (en && !(&v))
      return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    return v;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (halt_req) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = HALT;
        end else if (ext_stall) begin
          stall_c  = 1'b1;
        end else if (load_hazard) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          if (LOAD_BUBBLES > 1) begin
            state_d = LOAD_BUB;
            cnt_d   = LB_INIT;
          end
        end else if (branch_detect) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = BR_WAIT;
          cnt_d    = 8'd0;
        end
      end
      LOAD_BUB: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        if (halt_req)
          state_d = HALT;
        else if (cnt_q == 8'd0)
          state_d = RUN;
        else
          cnt_d = cnt_q - 8'd1;
      end
      BR_WAIT: begin
        // Resolution wins over any stall or halt arriving in the same cycle.
        if (branch_resolved) begin
          flush_c = branch_taken;
          state_d = RUN;
        end else begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          if (cnt_q == BR_LAST) begin
            state_d = HALT;
            err_d   = 1'b1;
          end else if (halt_req) begin
            state_d = HALT;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      HALT: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        if (resume)
          state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are forced low for the whole time reset is held.
  assign pc_stall       = stall_c  & ~reset;
  assign bubble         = bubble_c & ~reset;
  assign flush          = flush_c  & ~reset;
  assign halted         = (state_q == HALT) & ~reset;
  assign br_timeout_err = err_q & ~reset;
  assign state          = reset ? 2'b00 : state_q;
  assign stall_count    = stall_cnt_q;
  assign bubble_count   = bubble_cnt_q;

  always_comb begin
    stall_cnt_d  = sat_inc(stall_cnt_q, pc_stall);
    bubble_cnt_d = sat_inc(bubble_cnt_q, bubble);
    if (clear_counts) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      cnt_q        <= 8'd0;
      err_q        <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl with LOAD_BUBBLES=3, BR_TIMEOUT=8, CNT_WIDTH=4.
module tb_fetch_seq_ctrl;
  logic       clk, reset;
  logic       halt_req, resume, ext_stall, load_hazard;
  logic       branch_detect, branch_resolved, branch_taken, clear_counts;
  logic       pc_stall, bubble, flush, halted, br_timeout_err;
  logic [1:0] state;
  logic [3:0] stall_count, bubble_count;
  int n_chk, n_err;

  fetch_seq_ctrl #(.LOAD_BUBBLES(3), .BR_TIMEOUT(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .halt_req(halt_req), .resume(resume),
    .ext_stall(ext_stall), .load_hazard(load_hazard), .branch_detect(branch_detect),
    .branch_resolved(branch_resolved), .branch_taken(branch_taken),
    .clear_counts(clear_counts), .pc_stall(pc_stall), .bubble(bubble), .flush(flush),
    .halted(halted), .br_timeout_err(br_timeout_err), .state(state),
    .stall_count(stall_count), .bubble_count(bubble_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear_counts = 1'b1;
    cyc();
    clear_counts = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    halt_req = 1'b1;
    #2;
    n_chk++; if (pc_stall !== 1'b0 || bubble !== 1'b0 || halted !== 1'b0) begin n_err++;
      $display("FAIL rst_outputs_low: got stall=%b bubble=%b halted=%b want 0 0 0", pc_stall, bubble, halted); end
    halt_req = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    n_chk++; if (state !== 2'b00) begin n_err++;
      $display("FAIL rst_state: got %b want 00", state); end
    n_chk++; if (pc_stall !== 1'b0 || bubble !== 1'b0 || flush !== 1'b0) begin n_err++;
      $display("FAIL rst_idle_outputs: got stall=%b bubble=%b flush=%b want 0 0 0", pc_stall, bubble, flush); end
    for (int i = 0; i < 10; i++) cyc();
    n_chk++; if (stall_count !== 4'd0 || bubble_count !== 4'd0) begin n_err++;
      $display("FAIL rst_counters: got stall=%0d bubble=%0d want 0 0", stall_count, bubble_count); end
  endtask

  task automatic test_load_bubble();
    do_clear();
    load_hazard = 1'b1;
    #1;
    n_chk++; if (state !== 2'b00 || bubble !== 1'b1 || pc_stall !== 1'b1) begin n_err++;
      $display("FAIL lb_c1: got state=%b bubble=%b stall=%b want 00 1 1", state, bubble, pc_stall); end
    cyc();
    load_hazard = 1'b0;
    #1;
    n_chk++; if (state !== 2'b01 || bubble !== 1'b1) begin n_err++;
      $display("FAIL lb_c2: got state=%b bubble=%b want 01 1", state, bubble); end
    cyc();
    n_chk++; if (state !== 2'b01 || bubble !== 1'b1) begin n_err++;
      $display("FAIL lb_c3: got state=%b bubble=%b want 01 1", state, bubble); end
    cyc();
    n_chk++; if (state !== 2'b00 || bubble !== 1'b0) begin n_err++;
      $display("FAIL lb_done: got state=%b bubble=%b want 00 0", state, bubble); end
    n_chk++; if (bubble_count !== 4'd3 || stall_count !== 4'd3) begin n_err++;
      $display("FAIL lb_counts: got bubble=%0d stall=%0d want 3 3", bubble_count, stall_count); end
  endtask

  task automatic test_branch_taken();
    do_clear();
    branch_detect = 1'b1;
    #1;
    n_chk++; if (state !== 2'b00 || bubble !== 1'b1 || flush !== 1'b0) begin n_err++;
      $display("FAIL br_c1: got state=%b bubble=%b flush=%b want 00 1 0", state, bubble, flush); end
    cyc();
    branch_detect = 1'b0;
    #1;
    n_chk++; if (state !== 2'b10 || bubble !== 1'b1 || flush !== 1'b0) begin n_err++;
      $display("FAIL br_c2: got state=%b bubble=%b flush=%b want 10 1 0", state, bubble, flush); end
    cyc();
    branch_resolved = 1'b1;
    branch_taken = 1'b1;
    ext_stall = 1'b1;
    #1;
    n_chk++; if (flush !== 1'b1 || bubble !== 1'b0 || pc_stall !== 1'b0) begin n_err++;
      $display("FAIL br_resolve: got flush=%b bubble=%b stall=%b want 1 0 0", flush, bubble, pc_stall); end
    cyc();
    branch_resolved = 1'b0;
    branch_taken = 1'b0;
    ext_stall = 1'b0;
    #1;
    n_chk++; if (state !== 2'b00 || flush !== 1'b0) begin n_err++;
      $display("FAIL br_back_run: got state=%b flush=%b want 00 0", state, flush); end
    n_chk++; if (bubble_count !== 4'd2) begin n_err++;
      $display("FAIL br_bubble_count: got %0d want 2", bubble_count); end
  endtask

  task automatic test_branch_timeout();
    branch_detect = 1'b1;
    cyc();
    branch_detect = 1'b0;
    #1;
    n_chk++; if (br_timeout_err !== 1'b0) begin n_err++;
      $display("FAIL to_err_early: got %b want 0", br_timeout_err); end
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (state !== 2'b10 || bubble !== 1'b1 || flush !== 1'b0) begin n_err++;
        $display("FAIL to_wait_%0d: got state=%b bubble=%b flush=%b want 10 1 0", i, state, bubble, flush); end
      cyc();
    end
    n_chk++; if (state !== 2'b11 || halted !== 1'b1 || br_timeout_err !== 1'b1) begin n_err++;
      $display("FAIL to_halt: got state=%b halted=%b err=%b want 11 1 1", state, halted, br_timeout_err); end
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    #1;
    n_chk++; if (state !== 2'b00 || halted !== 1'b0 || br_timeout_err !== 1'b1) begin n_err++;
      $display("FAIL to_resume: got state=%b halted=%b err=%b want 00 0 1", state, halted, br_timeout_err); end
  endtask

  task automatic test_priority();
    halt_req = 1'b1;
    ext_stall = 1'b1;
    load_hazard = 1'b1;
    #1;
    n_chk++; if (pc_stall !== 1'b1 || bubble !== 1'b1) begin n_err++;
      $display("FAIL pri_outputs: got stall=%b bubble=%b want 1 1", pc_stall, bubble); end
    cyc();
    halt_req = 1'b0;
    ext_stall = 1'b0;
    load_hazard = 1'b0;
    #1;
    n_chk++; if (state !== 2'b11 || halted !== 1'b1) begin n_err++;
      $display("FAIL pri_halt: got state=%b halted=%b want 11 1", state, halted); end
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    do_clear();
    ext_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++; if (pc_stall !== 1'b1 || bubble !== 1'b0 || state !== 2'b00) begin n_err++;
        $display("FAIL freeze_%0d: got stall=%b bubble=%b state=%b want 1 0 00", i, pc_stall, bubble, state); end
      cyc();
    end
    ext_stall = 1'b0;
    #1;
    n_chk++; if (stall_count !== 4'd5 || bubble_count !== 4'd0) begin n_err++;
      $display("FAIL freeze_counts: got stall=%0d bubble=%0d want 5 0", stall_count, bubble_count); end
  endtask

  task automatic test_saturate();
    do_clear();
    ext_stall = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    #1;
    n_chk++; if (stall_count !== 4'd15) begin n_err++;
      $display("FAIL sat_value: got %0d want 15", stall_count); end
    clear_counts = 1'b1;
    cyc();
    clear_counts = 1'b0;
    ext_stall = 1'b0;
    #1;
    n_chk++; if (stall_count !== 4'd0) begin n_err++;
      $display("FAIL clear_beats_inc: got %0d want 0", stall_count); end
  endtask

  task automatic test_reset_mid_branch();
    branch_detect = 1'b1;
    cyc();
    branch_detect = 1'b0;
    cyc();
    n_chk++; if (state !== 2'b10) begin n_err++;
      $display("FAIL mid_in_wait: got state=%b want 10", state); end
    reset = 1'b1;
    #1;
    n_chk++; if (state !== 2'b00 || pc_stall !== 1'b0 || bubble !== 1'b0 || br_timeout_err !== 1'b0) begin n_err++;
      $display("FAIL mid_async_rst: got state=%b stall=%b bubble=%b err=%b want 00 0 0 0", state, pc_stall, bubble, br_timeout_err); end
    cyc();
    reset = 1'b0;
    #1;
    n_chk++; if (state !== 2'b00 || pc_stall !== 1'b0 || br_timeout_err !== 1'b0) begin n_err++;
      $display("FAIL mid_after_rst: got state=%b stall=%b err=%b want 00 0 0", state, pc_stall, br_timeout_err); end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    halt_req = 1'b0; resume = 1'b0; ext_stall = 1'b0; load_hazard = 1'b0;
    branch_detect = 1'b0; branch_resolved = 1'b0; branch_taken = 1'b0; clear_counts = 1'b0;
    test_reset();
    test_load_bubble();
    test_branch_taken();
    test_branch_timeout();
    test_priority();
    test_saturate();
    test_reset_mid_branch();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
